// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: passive checker on the LED_NS / LED_WE lamp buses of
// the traffic light controller. Decodes lamps into a phase and flags illegal
// codes, NS/WE conflicts, out-of-order phases and (optionally) wrong dwell.
// Optional feature macro: TRAFFIC_LIGHT_MONITOR_DWELL_CHECK_EN enables the
// dwell counter and err_status[3] DWELL_SHORT / err_status[4] DWELL_LONG.
// Without it those two bits are constant 0.
// The FSM state (SYNC/TRACK) is visible directly on the locked output.
module traffic_light_monitor #(
    parameter int GREEN_CYC  = 15,
    parameter int YELLOW_CYC = 3,
    parameter int ALLRED_CYC = 3,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       LED_NS,
    input  logic [2:0]       LED_WE,
    input  logic             err_clr,
    output logic [2:0]       phase,
    output logic             locked,
    output logic [4:0]       err_status,
    output logic             err_pulse,
    output logic [CNT_W-1:0] cycles_done
);

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    typedef enum logic [2:0] {
        PH_NS_G = 3'd0,
        PH_NS_Y = 3'd1,
        PH_AR1  = 3'd2,
        PH_WE_G = 3'd3,
        PH_WE_Y = 3'd4,
        PH_AR2  = 3'd5,
        PH_INV  = 3'd7
    } phase_t;

    typedef enum logic {
        ST_SYNC  = 1'b0,
        ST_TRACK = 1'b1
    } state_t;

    state_t state_q, state_d;
    phase_t phase_q, phase_d;
    phase_t raw_ph, cand_ph, succ_ph;
    logic   ns_legal, we_legal, code_bad, both_lit, all_red;
    logic [4:0] det;
    logic   cyc_inc;

`ifdef TRAFFIC_LIGHT_MONITOR_DWELL_CHECK_EN
    localparam logic [5:0] GREEN_REQ  = 6'(GREEN_CYC);
    localparam logic [5:0] YELLOW_REQ = 6'(YELLOW_CYC);
    localparam logic [5:0] ALLRED_REQ = 6'(ALLRED_CYC);
    localparam logic [4:0] DWELL_MAX  = 5'h1f;

    logic [4:0] dwell_q, dwell_d;
    logic       partial_q, partial_d;
    logic [5:0] req_cur;

    // Required dwell of the phase currently being tracked.
    always_comb begin
        case (phase_q)
            PH_NS_G, PH_WE_G: req_cur = GREEN_REQ;
            PH_NS_Y, PH_WE_Y: req_cur = YELLOW_REQ;
            default:          req_cur = ALLRED_REQ;
        endcase
    end
`endif

    // Lamp decode: legality, conflict, all-red and the raw (unresolved) phase.
    always_comb begin
        ns_legal = (LED_NS == RED) || (LED_NS == YEL) || (LED_NS == GRN);
        we_legal = (LED_WE == RED) || (LED_WE == YEL) || (LED_WE == GRN);
        code_bad = !ns_legal || !we_legal;
        both_lit = (LED_NS != RED) && (LED_WE != RED);
        all_red  = (LED_NS == RED) && (LED_WE == RED);
        if (LED_NS == GRN)      raw_ph = PH_NS_G;
        else if (LED_NS == YEL) raw_ph = PH_NS_Y;
        else if (LED_WE == GRN) raw_ph = PH_WE_G;
        else if (LED_WE == YEL) raw_ph = PH_WE_Y;
        else                    raw_ph = PH_AR1;  // all-red, resolved below
    end

    // Expected successor and the all-red resolution based on the tracked phase.
    always_comb begin
        case (phase_q)
            PH_NS_G: succ_ph = PH_NS_Y;
            PH_NS_Y: succ_ph = PH_AR1;
            PH_AR1:  succ_ph = PH_WE_G;
            PH_WE_G: succ_ph = PH_WE_Y;
            PH_WE_Y: succ_ph = PH_AR2;
            PH_AR2:  succ_ph = PH_NS_G;
            default: succ_ph = PH_INV;
        endcase
        cand_ph = raw_ph;
        if (all_red) begin
            case (phase_q)
                PH_NS_Y: cand_ph = PH_AR1;
                PH_WE_Y: cand_ph = PH_AR2;
                PH_AR1:  cand_ph = PH_AR1;
                PH_AR2:  cand_ph = PH_AR2;
                default: cand_ph = PH_AR1;  // out of order, flagged as BAD_SEQ
            endcase
        end
    end

    // Next-state, error detection and cycle-count strobe.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        det     = '0;
        cyc_inc = 1'b0;
`ifdef TRAFFIC_LIGHT_MONITOR_DWELL_CHECK_EN
        dwell_d   = dwell_q;
        partial_d = partial_q;
`endif
        if (code_bad || both_lit) begin
            // Abandoned phase: no dwell judgement, just resynchronise.
            det[0]  = code_bad;
            det[1]  = both_lit;
            state_d = ST_SYNC;
            phase_d = PH_INV;
`ifdef TRAFFIC_LIGHT_MONITOR_DWELL_CHECK_EN
            dwell_d   = '0;
            partial_d = 1'b0;
`endif
        end else if (state_q == ST_SYNC) begin
            if (all_red) begin
                phase_d = PH_INV;  // AR1 vs AR2 cannot be told apart yet
            end else begin
                state_d = ST_TRACK;
                phase_d = raw_ph;
`ifdef TRAFFIC_LIGHT_MONITOR_DWELL_CHECK_EN
                dwell_d   = 5'd1;
                partial_d = 1'b1;
`endif
            end
        end else begin
            if (cand_ph == phase_q) begin
`ifdef TRAFFIC_LIGHT_MONITOR_DWELL_CHECK_EN
                if (dwell_q != DWELL_MAX) begin
                    dwell_d = dwell_q + 5'd1;
                    // Fires exactly once, when dwell steps to required+1.
                    det[4] = ({1'b0, dwell_q} == req_cur);
                end
`endif
            end else begin
                det[2]  = (cand_ph != succ_ph);
                cyc_inc = (phase_q == PH_AR2) && (cand_ph == PH_NS_G);
                phase_d = cand_ph;
`ifdef TRAFFIC_LIGHT_MONITOR_DWELL_CHECK_EN
                det[3]    = !partial_q && ({1'b0, dwell_q} < req_cur);
                dwell_d   = 5'd1;
                partial_d = 1'b0;
`endif
            end
        end
    end

    // State, phase, sticky error register and completed-cycle counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_SYNC;
            phase_q     <= PH_INV;
            err_status  <= '0;
            err_pulse   <= 1'b0;
            cycles_done <= '0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            err_status <= err_clr ? det : (err_status | det);
            err_pulse  <= |det;
            if (cyc_inc) begin
                cycles_done <= cycles_done + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

`ifdef TRAFFIC_LIGHT_MONITOR_DWELL_CHECK_EN
    // Dwell counter and partial-entry flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            dwell_q   <= '0;
            partial_q <= 1'b0;
        end else begin
            dwell_q   <= dwell_d;
            partial_q <= partial_d;
        end
    end
`endif

    assign phase  = phase_q;
    assign locked = (state_q == ST_TRACK);

endmodule
